// File: rtl/gpio_hex_pkg.sv
// Shared constants for the GPIO hex display: segment patterns, blank code and
// the leading-zero mask helper.
package gpio_hex_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit i set when digit i is a leading zero: nibbles num_digits-1 down to i
    // are all zero. Digit 0 is never marked, so a zero value still shows "0".
    function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(
        input logic [31:0] value,
        input int          num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < num_digits) begin
                all_zero = all_zero && (value[4*i +: 4] == 4'h0);
                mask[i]  = all_zero && (i > 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/gpio_hex_display_seg7.sv
// Hex nibble to active-low seven-segment pattern; purely combinational.
module hex_to_seg7
    import gpio_hex_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG7_LUT[nibble_i];

endmodule

// File: rtl/gpio_hex_display.sv
// Double-buffered, time-multiplexed seven-segment driver for the io2 GPIO port.
// Written values are swapped in only at a scan-frame boundary.
module gpio_hex_display
    import gpio_hex_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  pending,
    output logic [31:0]           disp_value
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DIG_W-1:0]      dig_q,    dig_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [31:0]           disp_q,   disp_d;
    logic                  pend_q,   pend_d;
    logic [6:0]            seg_q,    seg_d;
    logic [NUM_DIGITS-1:0] an_q,     an_d;

    logic                  tick;
    logic                  frame_end;
    logic [MAX_DIGITS-1:0] blank_mask;
    logic                  blank;
    logic [3:0]            nibble;
    logic [6:0]            nibble_seg;

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (dig_q == DIG_LAST);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        dig_d    = dig_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;

        if (tick) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end

        // A write coinciding with the boundary bypasses the shadow so the
        // newest value is shown without waiting a whole extra frame.
        if (wr_en && frame_end) begin
            shadow_d = wr_data;
            disp_d   = wr_data;
            pend_d   = 1'b0;
        end else if (wr_en) begin
            shadow_d = wr_data;
            pend_d   = 1'b1;
        end else if (frame_end && pend_q) begin
            disp_d   = shadow_q;
            pend_d   = 1'b0;
        end
    end

    assign blank_mask = lead_zero_mask(disp_q, NUM_DIGITS);
    assign blank      = (BLANK_LEADING != 0) && blank_mask[dig_q];
    assign nibble     = disp_q[{dig_q, 2'b00} +: 4];

    hex_to_seg7 u_seg7 (
        .nibble_i (nibble),
        .seg_n_o  (nibble_seg)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (!blank) begin
            seg_d = nibble_seg;
            an_d  = ~(NUM_DIGITS'(1) << dig_q);
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dig_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign pending    = pend_q;
    assign disp_value = disp_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Self-checking bench for gpio_hex_display with a frame-level reference model
// (SCAN_DIV=4, NUM_DIGITS=8, so one frame is 32 cycles).
module tb_gpio_hex_display;

    localparam int NUM_DIGITS = 8;
    localparam int SCAN_DIV   = 4;
    localparam int FRAME      = NUM_DIGITS * SCAN_DIV;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  wr_en;
    logic [31:0]           wr_data;
    logic [6:0]            seg_n;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  pending;
    logic [31:0]           disp_value;

    gpio_hex_display #(
        .NUM_DIGITS    (NUM_DIGITS),
        .SCAN_DIV      (SCAN_DIV),
        .BLANK_LEADING (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .pending    (pending),
        .disp_value (disp_value)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: position within the frame plus shown/waiting values.
    int          m_pos;
    logic [31:0] m_disp;
    logic [31:0] m_shadow;
    logic        m_pend;
    logic [6:0]  m_seg;
    logic [7:0]  m_an;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a digit should look like: blank when everything from it upward is 0.
    function automatic void render(input int dig, input logic [31:0] v,
                                   output logic [6:0] s, output logic [7:0] a);
        if (dig > 0 && (v >> (4 * dig)) == 32'd0) begin
            s = 7'h7F;
            a = 8'hFF;
        end else begin
            s = seg_tab[v[4*dig +: 4]];
            a = ~(8'd1 << dig);
        end
    endfunction

    task automatic model_reset();
        m_pos    = 0;
        m_disp   = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
    endtask

    // One clock: drive inputs, advance the model across the edge, check at negedge.
    task automatic step(input logic we, input logic [31:0] d);
        bit frame;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        render(m_pos / SCAN_DIV, m_disp, m_seg, m_an);
        frame = (m_pos == FRAME - 1);
        if (we && frame) begin
            m_shadow = d;
            m_disp   = d;
            m_pend   = 1'b0;
        end else if (we) begin
            m_shadow = d;
            m_pend   = 1'b1;
        end else if (frame && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        m_pos = (m_pos + 1) % FRAME;
        @(negedge clk);
        wr_en = 1'b0;
        check("seg_n", {25'd0, seg_n}, {25'd0, m_seg});
        check("an_n", {24'd0, an_n}, {24'd0, m_an});
        check("pending", {31'd0, pending}, {31'd0, m_pend});
        check("disp_value", disp_value, m_disp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    task automatic idle_until(input int pos);
        while (m_pos != pos) step(1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        model_reset();

        @(negedge clk);
        check("rst_seg", {25'd0, seg_n}, 32'h7F);
        check("rst_an", {24'd0, an_n}, 32'hFF);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_disp", disp_value, 32'd0);
        rst_n = 1'b1;

        step(1'b0, 32'd0);
        check("first_an", {24'd0, an_n}, 32'hFE);
        check("first_seg", {25'd0, seg_n}, 32'h40);
        idle(40);

        step(1'b1, 32'h0000_12AF);
        idle(2 * FRAME);

        idle_until(3 * SCAN_DIV);
        step(1'b1, 32'h8765_4321);
        check("pend_after_write", {31'd0, pending}, 32'd1);
        check("disp_held", disp_value, 32'h0000_12AF);
        idle(FRAME + 8);

        idle_until(0);
        step(1'b1, 32'h1111_1111);
        idle(5);
        step(1'b1, 32'h2222_2222);
        idle(2 * FRAME);

        idle_until(FRAME - 1);
        step(1'b1, 32'hDEAD_BEEF);
        check("bypass_disp", disp_value, 32'hDEAD_BEEF);
        check("bypass_pending", {31'd0, pending}, 32'd0);
        idle(FRAME + 2);

        for (int i = 0; i < 300; i++) begin
            rnd = $urandom >> $urandom_range(0, 31);
            step($urandom_range(0, 9) == 0, rnd);
        end

        idle_until(5);
        step(1'b1, 32'h0ABC_0000);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", {25'd0, seg_n}, 32'h7F);
        check("async_rst_an", {24'd0, an_n}, 32'hFF);
        check("async_rst_pending", {31'd0, pending}, 32'd0);
        check("async_rst_disp", disp_value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 32'd0);
        check("post_rst_an", {24'd0, an_n}, 32'hFE);
        check("post_rst_seg", {25'd0, seg_n}, 32'h40);
        idle(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
